// File: rtl/note_judge_if.sv
// note_judge_if: play-control, key, chart ROM and result signals of the rhythm judge.
interface note_judge_if #(parameter int ADDR_W = 6);
    logic              map;
    logic              key_hit;
    logic              chart_note;
    logic [ADDR_W-1:0] chart_addr;
    logic              miss;
    logic              hit;
    logic              done;
    logic              note_active;
    logic [7:0]        hit_count;
    modport master (
        output map, key_hit, chart_note,
        input  chart_addr, miss, hit, done, note_active, hit_count
    );
    modport slave (
        input  map, key_hit, chart_note,
        output chart_addr, miss, hit, done, note_active, hit_count
    );
endinterface

// File: rtl/note_judge.sv
// note_judge: steps through the song chart beat by beat and grades key presses
// against each note's hit window, producing hit/miss pulses and a done level.
module note_judge #(
    parameter int TICKS_PER_BEAT = 12_500_000,
    parameter int WINDOW         = 5_000_000,
    parameter int SONG_BEATS     = 64,
    parameter int ADDR_W         = 6,
    parameter int TICK_W         = 24
) (
    input logic         clk,
    input logic         reset,
    note_judge_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(TICKS_PER_BEAT - 1);
    localparam logic [TICK_W-1:0] WIN_TICK  = TICK_W'(WINDOW);
    localparam logic [TICK_W-1:0] OPEN_TICK = TICK_W'(1);
    localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(SONG_BEATS - 1);
    state_t            state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [ADDR_W-1:0] beat_q, beat_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              win_q, win_d;
    logic              key_prev_q;
    logic              hit_q, hit_d;
    logic              miss_q, miss_d;
    logic              done_q, done_d;
    logic              press;
    logic              open_now;
    always_comb begin
        state_d  = state_q;
        tick_d   = tick_q;
        beat_d   = beat_q;
        cnt_d    = cnt_q;
        win_d    = win_q;
        hit_d    = 1'b0;
        miss_d   = 1'b0;
        press    = bus.key_hit & ~key_prev_q;
        // A window opening this very cycle already accepts a press.
        open_now = win_q | (tick_q == OPEN_TICK && bus.chart_note);
        if (!bus.map) begin
            state_d = IDLE;
            tick_d  = '0;
            beat_d  = '0;
            win_d   = 1'b0;
        end else if (state_q == IDLE) begin
            state_d = PLAY;
            cnt_d   = '0;
        end else if (state_q == PLAY) begin
            tick_d = tick_q + TICK_W'(1);
            if (tick_q == LAST_TICK) begin
                tick_d = '0;
                if (beat_q == LAST_BEAT) state_d = DONE;
                else beat_d = beat_q + ADDR_W'(1);
            end
            // Press wins over expiry in the same cycle.
            if (press && open_now) begin
                hit_d = 1'b1;
                win_d = 1'b0;
                cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            end else if (press) begin
                miss_d = 1'b1;
            end else if (open_now && tick_q == WIN_TICK) begin
                miss_d = 1'b1;
                win_d  = 1'b0;
            end else begin
                win_d = open_now;
            end
        end
        done_d = (state_d == DONE);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tick_q     <= '0;
            beat_q     <= '0;
            cnt_q      <= '0;
            win_q      <= 1'b0;
            key_prev_q <= 1'b0;
            hit_q      <= 1'b0;
            miss_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_q     <= tick_d;
            beat_q     <= beat_d;
            cnt_q      <= cnt_d;
            win_q      <= win_d;
            key_prev_q <= bus.key_hit;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            done_q     <= done_d;
        end
    end
    assign bus.chart_addr  = beat_q;
    assign bus.miss        = miss_q;
    assign bus.hit         = hit_q;
    assign bus.done        = done_q;
    assign bus.note_active = win_q;
    assign bus.hit_count   = cnt_q;
endmodule

// File: doc/note_judge.md
# note_judge

Rhythm-judging datapath for the game. It steps through a song chart beat by beat while play is enabled and opens a hit window on every charted note. It grades the player's key presses and produces the `miss` pulses and `done` level consumed by the game control FSM. It also reports hits and the current note window for the display path.

## Interface
Parameters:
- `TICKS_PER_BEAT`, 12_500_000: clock cycles per beat (≥ 4).
- `WINDOW`, 5_000_000: last tick index of the hit window; 1 ≤ WINDOW ≤ TICKS_PER_BEAT-2.
- `SONG_BEATS`, 64: beats in the song (≤ 2^ADDR_W).
- `ADDR_W`, 6: chart address width.
- `TICK_W`, 24: tick counter width; must hold TICKS_PER_BEAT-1.

Ports:
- `clk`  in  1  single system clock.
- `reset`  in  1  synchronous, active-high reset.
- `map`  in  1  play enable from the control FSM (level).
- `key_hit`  in  1  player hit key, debounced, active-high level.
- `chart_addr`  out  ADDR_W  current beat index into the chart ROM.
- `chart_note`  in  1  note-present bit from the synchronous chart ROM, valid 1 cycle after `chart_addr` changes.
- `miss`  out  1  single-cycle miss pulse.
- `hit`  out  1  single-cycle hit pulse.
- `done`  out  1  song finished; level.
- `note_active`  out  1  hit window currently open.
- `hit_count`  out  8  hits this song, saturating at 255.

## Operation
- States: IDLE, PLAY, DONE.
  - IDLE: tick=0, beat=0, window closed. Go to PLAY when `map`=1.
  - PLAY: tick runs 0..TICKS_PER_BEAT-1. Beat increments when tick wraps. After beat SONG_BEATS-1 reaches tick TICKS_PER_BEAT-1, go to DONE.
  - DONE: `done`=1. Hold until `map`=0, then IDLE.
  - From PLAY or DONE, `map`=0 forces IDLE next cycle. Window is cleared; no `miss` or `hit` is produced on that transition.
- `chart_addr` = beat counter.
- Press edge = `key_hit` & ~key_prev. key_prev is registered every cycle in all states.
- Window open: in PLAY, at tick==1 with `chart_note`=1.
- Press edge while window open: `hit` pulse, `hit_count`+1 (saturating), window closes.
- Window open at tick==WINDOW with no press edge that cycle: `miss` pulse, window closes.
- Press edge in PLAY with window closed: stray press, `miss` pulse. This includes a second press after a hit in the same beat.
- Press edge at tick==1 in the same cycle the window opens: counts as a hit.
- Presses in IDLE and DONE are ignored.
- `hit_count` clears on entry to PLAY from IDLE. It holds through DONE.
- `note_active` = window-open register.

## Timing
- Reset values: state IDLE, all counters 0, key_prev 0, `miss`=0, `hit`=0, `done`=0, `note_active`=0, `hit_count`=0, `chart_addr`=0.
- Reset mid-song returns everything to reset values on the next edge.
- `map` sampled high in IDLE at cycle n: PLAY with tick=0, beat=0 from cycle n+1.
- `note_active` rises 1 cycle after the tick==1 sample. It stays high through tick WINDOW unless a hit closes it.
- `hit` and `miss` are registered: high exactly 1 cycle, the cycle after the deciding edge or expiry.
- At most one of `hit`/`miss` per cycle. Simultaneous press edge and expiry resolves as hit.
- `done` rises 1 cycle after the final tick of beat SONG_BEATS-1. A window still open on the last beat has already expired, since WINDOW < TICKS_PER_BEAT-1.
- Miss total per song = unhit notes + stray presses. The control FSM counts each 1-cycle pulse once.

## Test plan
Bench parameters: TICKS_PER_BEAT=8, WINDOW=3, SONG_BEATS=4, chart = 1,0,1,1.
- Raise `map` with no key activity -> `miss` pulses for beats 0, 2 and 3 (3 total); `hit` never asserted; `done`=1 from cycle 33 after PLAY entry; `hit_count`=0.
- Press edge at tick 2 of beats 0, 2 and 3 -> 3 `hit` pulses, zero `miss`, `hit_count`=3, `done` asserted.
- Press edge during beat 1 (no note) -> 1 `miss`. Second press in beat 0 after a hit -> 1 `miss`. `hit_count` unaffected by either.
- Press edge exactly at tick 3 of beat 0 -> `hit`, not `miss`. Press edge at tick 4 -> `miss` from expiry, then a second `miss` for the stray press.
- Drop `map` at beat 2 tick 2 with window open -> IDLE next cycle, no pulse. Re-raise `map` -> beat 0 restart, `hit_count`=0.
- Assert `reset` for 1 cycle mid-song with `key_hit` held high -> all outputs 0. Held key produces no edge after reset.
